// File: rtl/tmnt_rom_port.sv
// tmnt_rom_port: arbitrates the 68k, tile, sprite and theme ROM read ports onto one SDRAM read channel
// Ports: clk_sys/reset (async, active-high); <ch>_rom_req strobe, <ch>_rom_addr word address, <ch>_rom_dout data;
//        sdram_dtack 68k ready; sd_req/sd_addr to SDRAM, sd_ack/sd_valid/sd_dout from SDRAM.
module tmnt_rom_port #(
  parameter logic [24:0] M68K_BASE  = 25'h0000000,
  parameter logic [24:0] TILES_BASE = 25'h0100000,
  parameter logic [24:0] SPR_BASE   = 25'h0200000,
  parameter logic [24:0] THEME_BASE = 25'h0400000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        m68k_rom_req,
  input  logic [17:0] m68k_rom_addr,
  output logic [15:0] m68k_rom_dout,
  output logic        sdram_dtack,
  input  logic        tiles_rom_req,
  input  logic [17:0] tiles_rom_addr,
  output logic [31:0] tiles_rom_dout,
  input  logic        spr_rom_req,
  input  logic [18:0] spr_rom_addr,
  output logic [31:0] spr_rom_dout,
  input  logic        theme_rom_req,
  input  logic [17:0] theme_rom_addr,
  output logic [31:0] theme_rom_dout,
  output logic        sd_req,
  output logic [24:0] sd_addr,
  input  logic        sd_ack,
  input  logic        sd_valid,
  input  logic [31:0] sd_dout
);
  localparam logic [1:0] S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2;
  logic [1:0]  st_q, st_d;
  logic [3:0]  pend_q, pend_d, req;
  logic [1:0]  ch_q, ch_d, sel;
  logic        wsel_q, wsel_d;
  logic [24:0] addr_q, addr_d, sel_addr;
  logic [17:0] am_q, at_q, ah_q;
  logic [18:0] as_q;
  logic [15:0] dm_q;
  logic [31:0] dt_q, ds_q, dh_q;
  logic        dtack_q, dtack_d, grant, done;
  assign req = {theme_rom_req, spr_rom_req, tiles_rom_req, m68k_rom_req};
  assign sel = pend_q[0] ? 2'd0 : pend_q[1] ? 2'd1 : pend_q[2] ? 2'd2 : 2'd3;
  // 68k addresses 16-bit words, so two consecutive words share one 32-bit SDRAM fetch
  assign sel_addr = sel == 2'd0 ? M68K_BASE + 25'({am_q[17:1], 2'b00}) :
                    sel == 2'd1 ? TILES_BASE + 25'({at_q, 2'b00}) :
                    sel == 2'd2 ? SPR_BASE + 25'({as_q, 2'b00}) :
                                  THEME_BASE + 25'({ah_q, 2'b00});
  assign grant = st_q == S_IDLE && |pend_q;
  assign done = st_q == S_WAIT && sd_valid;
  always_comb begin
    st_d = grant ? S_ISSUE : (st_q == S_ISSUE && sd_ack) ? S_WAIT : done ? S_IDLE : st_q;
    // a strobe arriving on the granted channel in the grant cycle re-arms it for a second fetch
    pend_d = (pend_q & ~(grant ? 4'b0001 << sel : 4'b0000)) | req;
    ch_d = grant ? sel : ch_q;
    // word select is frozen at grant so a later 68k strobe cannot alter the half returned
    wsel_d = grant ? am_q[0] : wsel_q;
    addr_d = grant ? sel_addr : addr_q;
    dtack_d = m68k_rom_req ? 1'b0 : (done && ch_q == 2'd0 && !pend_q[0]) ? 1'b1 : dtack_q;
  end
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      st_q <= S_IDLE;
      pend_q <= '0;
      ch_q <= '0;
      wsel_q <= 1'b0;
      addr_q <= '0;
      dtack_q <= 1'b1;
      am_q <= '0;
      at_q <= '0;
      as_q <= '0;
      ah_q <= '0;
      dm_q <= '0;
      dt_q <= '0;
      ds_q <= '0;
      dh_q <= '0;
    end else begin
      st_q <= st_d;
      pend_q <= pend_d;
      ch_q <= ch_d;
      wsel_q <= wsel_d;
      addr_q <= addr_d;
      dtack_q <= dtack_d;
      if (m68k_rom_req) am_q <= m68k_rom_addr;
      if (tiles_rom_req) at_q <= tiles_rom_addr;
      if (spr_rom_req) as_q <= spr_rom_addr;
      if (theme_rom_req) ah_q <= theme_rom_addr;
      if (done && ch_q == 2'd0) dm_q <= wsel_q ? sd_dout[31:16] : sd_dout[15:0];
      if (done && ch_q == 2'd1) dt_q <= sd_dout;
      if (done && ch_q == 2'd2) ds_q <= sd_dout;
      if (done && ch_q == 2'd3) dh_q <= sd_dout;
    end
  end
  assign sd_req = st_q == S_ISSUE;
  assign sd_addr = addr_q;
  assign sdram_dtack = dtack_q;
  assign m68k_rom_dout = dm_q;
  assign tiles_rom_dout = dt_q;
  assign spr_rom_dout = ds_q;
  assign theme_rom_dout = dh_q;
endmodule
